// File: rtl/sample_readout.sv
// -----------------------------------------------------------------------------
// sample_readout
//   Walks the circular capture buffer from a trigger-aligned start address once
//   a capture has finished. Each stored sample is streamed to the host link over
//   a valid/ready interface. The block sits between the capture RAM read port
//   (1-cycle-latency synchronous RAM) and the host transmit path.
//
// Parameters
//   WIDTH   sample width in bits
//   ADDR_W  buffer address width, depth = 2**ADDR_W samples
//
// Ports
//   clk          system clock, all logic on posedge
//   rs_n         asynchronous active-low reset
//   start        1-cycle readout request, ignored while busy
//   abort        synchronous cancel of a running readout
//   trig_addr    address of the oldest sample, sampled on accepted start
//   count        number of samples to read, sampled on accepted start
//   ram_rd_en    RAM read strobe
//   ram_addr     RAM read address
//   ram_rd_data  RAM read data, valid the cycle after ram_rd_en
//   out_data     streamed sample
//   out_valid    out_data valid
//   out_ready    downstream ready
//   out_last     final sample of the readout, qualified by out_valid
//   busy         readout in progress (READ/LATCH/SEND/DONE)
//   done         1-cycle pulse on normal completion
// -----------------------------------------------------------------------------
module sample_readout #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rs_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] trig_addr,
   input  logic [ADDR_W:0]   count,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [WIDTH-1:0]  ram_rd_data,
   output logic [WIDTH-1:0]  out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_LATCH = 3'd2,
      S_SEND  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Full buffer depth expressed in the count width.
   localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] REM_ONE = {{ADDR_W{1'b0}}, 1'b1};

   state_t            state_q;
   logic [ADDR_W-1:0] ptr_q;
   logic [ADDR_W:0]   rem_q;
   logic              ram_rd_en_q;
   logic [WIDTH-1:0]  out_data_q;
   logic              out_valid_q;
   logic              out_last_q;
   logic              busy_q;
   logic              done_q;

   logic [ADDR_W:0]   count_clamped_d;
   logic [ADDR_W-1:0] ptr_inc_d;
   logic [ADDR_W:0]   rem_dec_d;

   always_comb begin
      count_clamped_d = (count > DEPTH) ? DEPTH : count;
      // Natural modulo-depth wrap of the read pointer.
      ptr_inc_d       = ptr_q + ADDR_W'(1);
      rem_dec_d       = rem_q - REM_ONE;
   end

   always_ff @(posedge clk or negedge rs_n) begin
      if (!rs_n) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         rem_q       <= '0;
         ram_rd_en_q <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         // Strobes are single-cycle unless re-armed on a transition below.
         ram_rd_en_q <= 1'b0;
         done_q      <= 1'b0;

         if (abort && (state_q != S_IDLE)) begin
            // Abort wins over a simultaneous handshake and suppresses done.
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start && !abort) begin
                     ptr_q  <= trig_addr;
                     rem_q  <= count_clamped_d;
                     busy_q <= 1'b1;
                     if (count == '0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                     end else begin
                        state_q     <= S_READ;
                        ram_rd_en_q <= 1'b1;
                     end
                  end
               end
               S_READ: begin
                  state_q <= S_LATCH;
               end
               S_LATCH: begin
                  out_data_q  <= ram_rd_data;
                  out_valid_q <= 1'b1;
                  out_last_q  <= (rem_q == REM_ONE);
                  state_q     <= S_SEND;
               end
               S_SEND: begin
                  // Data is held in out_data_q, so backpressure never re-reads RAM.
                  if (out_ready) begin
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     ptr_q       <= ptr_inc_d;
                     rem_q       <= rem_dec_d;
                     if (rem_q == REM_ONE) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                     end else begin
                        state_q     <= S_READ;
                        ram_rd_en_q <= 1'b1;
                     end
                  end
               end
               S_DONE: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
               default: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   // The pointer already holds the address of the sample being read in READ.
   assign ram_addr  = ptr_q;
   assign ram_rd_en = ram_rd_en_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_sample_readout.sv
// -----------------------------------------------------------------------------
// tb_sample_readout
//   Directed bench for sample_readout with ADDR_W=4, WIDTH=8 and a behavioural
//   synchronous RAM preloaded with mem[i] = 8'hA0 + i. Inputs change 1 time unit
//   after posedge; outputs are sampled on negedge. Cycle numbers are relative to
//   the edge that accepts start: the cycle right after that edge is 1.
// -----------------------------------------------------------------------------
module tb_sample_readout;

   localparam int WIDTH  = 8;
   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              rs_n = 1'b1;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [ADDR_W-1:0] trig_addr = '0;
   logic [ADDR_W:0]   count = '0;
   logic              ram_rd_en;
   logic [ADDR_W-1:0] ram_addr;
   logic [WIDTH-1:0]  ram_rd_data = '0;
   logic [WIDTH-1:0]  out_data;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic              out_last;
   logic              busy;
   logic              done;

   sample_readout #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
      .clk         (clk),
      .rs_n        (rs_n),
      .start       (start),
      .abort       (abort),
      .trig_addr   (trig_addr),
      .count       (count),
      .ram_rd_en   (ram_rd_en),
      .ram_addr    (ram_addr),
      .ram_rd_data (ram_rd_data),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_last    (out_last),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   // Capture RAM stand-in: 1-cycle read latency.
   logic [WIDTH-1:0] mem [0:15];
   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'(8'hA0 + i);
   end
   always @(posedge clk) if (ram_rd_en) ram_rd_data <= mem[ram_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;
   int e0       = 0;
   int mon_rel;
   int first_valid = -1;
   int rd_rel_q[$];
   int addr_q[$];
   int data_q[$];
   int last_q[$];
   int done_q[$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Transaction log, sampled mid-cycle.
   always @(negedge clk) begin
      if (rs_n) begin
         mon_rel = cyc - e0 + 1;
         if (ram_rd_en) begin
            rd_rel_q.push_back(mon_rel);
            addr_q.push_back(int'(ram_addr));
         end
         if (out_valid && out_ready && !abort) begin
            data_q.push_back(int'(out_data));
            last_q.push_back(int'(out_last));
            $display("xfer: cycle %0d data=%02h last=%0b", mon_rel, out_data, out_last);
         end
         if (out_valid && first_valid < 0) first_valid = mon_rel;
         if (done) done_q.push_back(mon_rel);
      end
   end

   task automatic clear_log();
      rd_rel_q.delete();
      addr_q.delete();
      data_q.delete();
      last_q.delete();
      done_q.delete();
      first_valid = -1;
   endtask

   task automatic do_start(input logic [ADDR_W-1:0] ta, input logic [ADDR_W:0] cnt);
      @(posedge clk); #1;
      clear_log();
      trig_addr = ta;
      count     = cnt;
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      e0    = cyc;
   endtask

   task automatic wait_idle(input string tag, input int max_cyc);
      int n = 0;
      while (busy && n < max_cyc) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq(tag, 32'(busy), 32'd0);
   endtask

   // Expected stream: n samples from address sa, wrapping at 16; last only on final.
   task automatic check_stream(input string tag, input int sa, input int n);
      check_eq({tag, "_nsamp"}, 32'(data_q.size()), 32'(n));
      check_eq({tag, "_nread"}, 32'(addr_q.size()), 32'(n));
      for (int i = 0; i < n && i < data_q.size(); i++) begin
         check_eq($sformatf("%s_data%0d", tag, i), 32'(data_q[i]), 32'(8'hA0 + ((sa + i) % 16)));
         check_eq($sformatf("%s_last%0d", tag, i), 32'(last_q[i]), 32'(i == n - 1));
      end
      for (int i = 0; i < n && i < addr_q.size(); i++)
         check_eq($sformatf("%s_addr%0d", tag, i), 32'(addr_q[i]), 32'((sa + i) % 16));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #2 rs_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_valid", 32'(out_valid), 32'd0);
      check_eq("rst_rd_en", 32'(ram_rd_en), 32'd0);
      check_eq("rst_busy",  32'(busy),      32'd0);
      check_eq("rst_done",  32'(done),      32'd0);
      check_eq("rst_addr",  32'(ram_addr),  32'd0);
      rs_n = 1'b1;

      // 1: basic readout, trig 3, count 4, no backpressure
      do_start(4'd3, 5'd4);
      wait_idle("t1_timeout", 100);
      check_stream("t1", 3, 4);
      for (int i = 0; i < 4 && i < rd_rel_q.size(); i++)
         check_eq($sformatf("t1_rd_cycle%0d", i), 32'(rd_rel_q[i]), 32'(1 + 3 * i));
      check_eq("t1_first_valid", 32'(first_valid), 32'd3);
      check_eq("t1_ndone", 32'(done_q.size()), 32'd1);
      if (done_q.size() > 0) check_eq("t1_done_cycle", 32'(done_q[0]), 32'd13);

      // 2: wrap across end of buffer
      do_start(4'd14, 5'd4);
      wait_idle("t2_timeout", 100);
      check_stream("t2", 14, 4);

      // 3: 5 cycles of backpressure while A4 is offered
      do_start(4'd3, 5'd4);
      repeat (5) begin @(posedge clk); #1; end
      out_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check_eq("t3_hold_valid", 32'(out_valid), 32'd1);
         check_eq("t3_hold_data",  32'(out_data),  32'hA4);
         check_eq("t3_hold_rd_en", 32'(ram_rd_en), 32'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      wait_idle("t3_timeout", 100);
      check_stream("t3", 3, 4);
      check_eq("t3_ndone", 32'(done_q.size()), 32'd1);

      // 4a: count 0 -> immediate done, no RAM access, no valid
      do_start(4'd7, 5'd0);
      wait_idle("t4a_timeout", 20);
      check_eq("t4a_nread", 32'(rd_rel_q.size()), 32'd0);
      check_eq("t4a_valid_seen", 32'(first_valid), 32'hFFFF_FFFF);
      check_eq("t4a_ndone", 32'(done_q.size()), 32'd1);
      if (done_q.size() > 0) check_eq("t4a_done_cycle", 32'(done_q[0]), 32'd1);

      // 4b: count 20 clamps to 16, last sample is A4 for trig 5
      do_start(4'd5, 5'd20);
      wait_idle("t4b_timeout", 200);
      check_stream("t4b", 5, 16);
      if (data_q.size() > 0) check_eq("t4b_final", 32'(data_q[data_q.size() - 1]), 32'hA4);

      // 5: async reset while second sample is valid, then clean restart
      do_start(4'd3, 5'd4);
      repeat (5) begin @(posedge clk); #1; end
      #2;
      check_eq("t5_pre_valid", 32'(out_valid), 32'd1);
      rs_n = 1'b0;
      #1;
      check_eq("t5_rst_valid", 32'(out_valid), 32'd0);
      check_eq("t5_rst_data",  32'(out_data),  32'd0);
      check_eq("t5_rst_busy",  32'(busy),      32'd0);
      check_eq("t5_rst_addr",  32'(ram_addr),  32'd0);
      check_eq("t5_rst_rd_en", 32'(ram_rd_en), 32'd0);
      repeat (2) begin @(posedge clk); #1; end
      rs_n = 1'b1;
      do_start(4'd0, 5'd2);
      wait_idle("t5_timeout", 50);
      check_stream("t5", 0, 2);
      check_eq("t5_ndone", 32'(done_q.size()), 32'd1);

      // 6a: start while busy is ignored
      do_start(4'd3, 5'd4);
      @(posedge clk); #1;
      trig_addr = 4'd9;
      count     = 5'd1;
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle("t6a_timeout", 100);
      check_stream("t6a", 3, 4);
      check_eq("t6a_ndone", 32'(done_q.size()), 32'd1);

      // 6b: abort in SEND with out_ready=1
      do_start(4'd3, 5'd4);
      repeat (2) begin @(posedge clk); #1; end
      check_eq("t6b_pre_valid", 32'(out_valid), 32'd1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check_eq("t6b_busy",  32'(busy),      32'd0);
      check_eq("t6b_valid", 32'(out_valid), 32'd0);
      check_eq("t6b_last",  32'(out_last),  32'd0);
      repeat (10) begin @(posedge clk); #1; end
      check_eq("t6b_nsamp", 32'(data_q.size()),   32'd0);
      check_eq("t6b_nread", 32'(rd_rel_q.size()), 32'd1);
      check_eq("t6b_ndone", 32'(done_q.size()),   32'd0);

      // 6c: abort together with start in IDLE -> start ignored
      clear_log();
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      check_eq("t6c_busy", 32'(busy), 32'd0);
      repeat (3) begin @(posedge clk); #1; end
      check_eq("t6c_nread", 32'(rd_rel_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
